// File: rtl/inst_buffer_pkg.sv
// Shared widths, default sizing and the decode-queue entry layout for the instruction buffer.
package inst_buffer_pkg;

    localparam int unsigned INST_ADDR_W      = 32;
    localparam int unsigned INST_W           = 32;
    localparam int unsigned IBUF_DEPTH       = 16;
    localparam int unsigned IBUF_OUTSTANDING = 2;
    localparam int unsigned IBUF_FULL_MARGIN = 2;

    typedef struct packed {
        logic [INST_ADDR_W-1:0] pc;
        logic [INST_W-1:0]      inst;
    } ibuf_entry_t;

    localparam int unsigned IBUF_ENTRY_W = $bits(ibuf_entry_t);

endpackage

// File: rtl/ibuffer_fifo.sv
// Register-array FIFO with synchronous clear and a combinational head read.
module ibuffer_fifo #(
    parameter int unsigned WIDTH = 64,
    parameter int unsigned DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     resetn,
    input  logic                     clear,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         wdata,
    output logic [WIDTH-1:0]         rdata,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    rd_ptr;
    logic [AW-1:0]    wr_ptr;
    logic             do_push;
    logic             do_pop;

    // A full FIFO still accepts a push when the head leaves in the same cycle.
    assign do_pop  = pop && (count != '0);
    assign do_push = push && ((count != CW'(DEPTH)) || do_pop);
    assign rdata   = mem[rd_ptr];

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (clear) begin
            rd_ptr <= wr_ptr;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            mem <= '{default: '0};
        end else if (do_push && !clear) begin
            mem[wr_ptr] <= wdata;
        end
    end

`ifndef SYNTHESIS
    overflow_push: assert property (@(posedge clk) disable iff (!resetn)
        !(push && !clear && !do_push))
        else $warning("ibuffer_fifo: push into full queue discarded");
`endif

endmodule

// File: rtl/inst_buffer.sv
// Fetch-side instruction buffer: pairs returned words with their PCs, queues them for decode,
// back-pressures fetch and discards stale returns after a redirect.
module inst_buffer
    import inst_buffer_pkg::*;
#(
    parameter int unsigned DEPTH           = IBUF_DEPTH,
    parameter int unsigned MAX_OUTSTANDING = IBUF_OUTSTANDING,
    parameter int unsigned FULL_MARGIN     = IBUF_FULL_MARGIN
) (
    input  logic                   clk,
    input  logic                   resetn,
    input  logic                   flush,
    input  logic                   branch_flag,
    input  logic                   inst_req,
    input  logic                   inst_addr_ok,
    input  logic [INST_ADDR_W-1:0] inst_pc,
    input  logic                   inst_data_ok,
    input  logic [INST_W-1:0]      inst_rdata,
    output logic                   ibuffer_full,
    output logic                   id_valid,
    output logic [INST_ADDR_W-1:0] id_pc,
    output logic [INST_W-1:0]      id_inst,
    input  logic                   id_ready
);

    localparam int unsigned CW = $clog2(DEPTH) + 1;
    localparam int unsigned QW = $clog2(MAX_OUTSTANDING) + 1;
    localparam int unsigned DW = $clog2(MAX_OUTSTANDING + 1) + 1;
    localparam int unsigned SW = CW + 1;

    logic                   accept;
    logic                   redirect;
    logic                   drop_hit;
    logic                   live_hit;
    logic [QW-1:0]          pend_count;
    logic [INST_ADDR_W-1:0] pend_pc;
    logic [CW-1:0]          buf_count;
    ibuf_entry_t            head;
    ibuf_entry_t            push_entry;
    logic [DW-1:0]          drop_cnt;
    logic [DW-1:0]          drop_nxt;
    logic [SW-1:0]          occupancy;

    assign accept   = inst_req && inst_addr_ok;
    assign redirect = flush || branch_flag;
    assign drop_hit = inst_data_ok && (drop_cnt != '0);
    assign live_hit = inst_data_ok && (drop_cnt == '0) && (pend_count != '0);

    assign push_entry = '{pc: pend_pc, inst: inst_rdata};

    // PCs of live requests, in issue order; stale requests live only in drop_cnt.
    ibuffer_fifo #(
        .WIDTH (INST_ADDR_W),
        .DEPTH (MAX_OUTSTANDING)
    ) u_pend_q (
        .clk    (clk),
        .resetn (resetn),
        .clear  (redirect),
        .push   (accept && !redirect),
        .pop    (live_hit && !redirect),
        .wdata  (inst_pc),
        .rdata  (pend_pc),
        .count  (pend_count)
    );

    ibuffer_fifo #(
        .WIDTH (IBUF_ENTRY_W),
        .DEPTH (DEPTH)
    ) u_buf_q (
        .clk    (clk),
        .resetn (resetn),
        .clear  (redirect),
        .push   (live_hit && !redirect),
        .pop    (id_valid && id_ready && !redirect),
        .wdata  (push_entry),
        .rdata  (head),
        .count  (buf_count)
    );

    // On redirect every request still owed a return, including one accepted now, becomes a drop.
    always_comb begin
        drop_nxt = drop_cnt;
        if (redirect) begin
            drop_nxt = drop_cnt + DW'(pend_count) + DW'(accept) - DW'(live_hit) - DW'(drop_hit);
        end else if (drop_hit) begin
            drop_nxt = drop_cnt - DW'(1);
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) drop_cnt <= '0;
        else         drop_cnt <= drop_nxt;
    end

    assign occupancy    = SW'(buf_count) + SW'(pend_count);
    assign ibuffer_full = (occupancy >= SW'(DEPTH - FULL_MARGIN)) ||
                          (pend_count == QW'(MAX_OUTSTANDING));

    assign id_valid = (buf_count != '0);
    assign id_pc    = head.pc;
    assign id_inst  = head.inst;

`ifndef SYNTHESIS
    orphan_return: assert property (@(posedge clk) disable iff (!resetn)
        !(inst_data_ok && (drop_cnt == '0) && (pend_count == '0)))
        else $warning("inst_buffer: data return with no fetch outstanding ignored");
`endif

endmodule

// File: tb/tb_inst_buffer.sv
// Randomized and directed bench for inst_buffer against a queue-based reference model.
module tb_inst_buffer;

    logic        clk;
    logic        resetn;
    logic        flush;
    logic        branch_flag;
    logic        inst_req;
    logic        inst_addr_ok;
    logic [31:0] inst_pc;
    logic        inst_data_ok;
    logic [31:0] inst_rdata;
    logic        ibuffer_full;
    logic        id_valid;
    logic [31:0] id_pc;
    logic [31:0] id_inst;
    logic        id_ready;

    int n_cmp = 0;
    int n_bad = 0;

    logic [63:0] mq[$];
    logic [31:0] pq[$];
    int          mdrop = 0;

    inst_buffer dut (
        .clk          (clk),
        .resetn       (resetn),
        .flush        (flush),
        .branch_flag  (branch_flag),
        .inst_req     (inst_req),
        .inst_addr_ok (inst_addr_ok),
        .inst_pc      (inst_pc),
        .inst_data_ok (inst_data_ok),
        .inst_rdata   (inst_rdata),
        .ibuffer_full (ibuffer_full),
        .id_valid     (id_valid),
        .id_pc        (id_pc),
        .id_inst      (id_inst),
        .id_ready     (id_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
        end
    endtask

    function automatic bit model_full();
        return ((mq.size() + pq.size()) >= 14) || (pq.size() == 2);
    endfunction

    function automatic int outstanding();
        return pq.size() + mdrop;
    endfunction

    // Reference model: advances on each rising edge from the inputs, then compares the DUT.
    initial begin
        bit acc, redir, live, dhit;
        logic [63:0] exp_e;
        forever begin
            @(posedge clk);
            if (!resetn) begin
                mq.delete();
                pq.delete();
                mdrop = 0;
            end else begin
                acc   = inst_req && inst_addr_ok;
                redir = flush || branch_flag;
                live  = inst_data_ok && (mdrop == 0) && (pq.size() > 0);
                dhit  = inst_data_ok && (mdrop > 0);
                if (redir) begin
                    mdrop = pq.size() - int'(live) + int'(acc) + mdrop - int'(dhit);
                    mq.delete();
                    pq.delete();
                end else begin
                    if (dhit) mdrop--;
                    if (id_ready && mq.size() > 0) void'(mq.pop_front());
                    if (live) begin
                        logic [31:0] p;
                        p = pq.pop_front();
                        if (mq.size() < 16) mq.push_back({p, inst_rdata});
                    end
                    if (acc && pq.size() < 2) pq.push_back(inst_pc);
                end
            end
            #1;
            check("id_valid", 64'(id_valid), 64'(mq.size() != 0));
            check("ibuffer_full", 64'(ibuffer_full), 64'(model_full()));
            if (mq.size() != 0) begin
                exp_e = mq[0];
                check("id_pc", 64'(id_pc), 64'(exp_e[63:32]));
                check("id_inst", 64'(id_inst), 64'(exp_e[31:0]));
            end
        end
    end

    // One cycle of directed stimulus; returns shortly after the edge that applies it.
    task automatic step(input logic req, input logic [31:0] pc, input logic dok,
                        input logic [31:0] rd, input logic rdy, input logic fl, input logic br);
        @(negedge clk);
        inst_req     = req;
        inst_addr_ok = req;
        inst_pc      = pc;
        inst_data_ok = dok;
        inst_rdata   = rd;
        id_ready     = rdy;
        flush        = fl;
        branch_flag  = br;
        @(posedge clk);
        #2;
    endtask

    task automatic idle(input logic rdy);
        step(1'b0, 32'h0, 1'b0, 32'h0, rdy, 1'b0, 1'b0);
    endtask

    initial begin
        int k;
        logic [31:0] pc;
        resetn = 1'b0;
        flush = 1'b0; branch_flag = 1'b0; inst_req = 1'b0; inst_addr_ok = 1'b0;
        inst_pc = '0; inst_data_ok = 1'b0; inst_rdata = '0; id_ready = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        check("rst_valid", 64'(id_valid), 64'd0);
        check("rst_full", 64'(ibuffer_full), 64'd0);
        check("rst_pc", 64'(id_pc), 64'd0);
        check("rst_inst", 64'(id_inst), 64'd0);
        @(negedge clk);
        resetn = 1'b1;

        // Two fetches returned in order, each visible one cycle after its data.
        step(1'b1, 32'hBFC0_0000, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
        check("a_empty", 64'(id_valid), 64'd0);
        step(1'b1, 32'hBFC0_0004, 1'b1, 32'h2408_0001, 1'b1, 1'b0, 1'b0);
        check("a_pc0", 64'(id_pc), 64'hBFC0_0000);
        check("a_inst0", 64'(id_inst), 64'h2408_0001);
        step(1'b0, 32'h0, 1'b1, 32'h2409_0002, 1'b1, 1'b0, 1'b0);
        check("a_pc1", 64'(id_pc), 64'hBFC0_0004);
        check("a_inst1", 64'(id_inst), 64'h2409_0002);
        idle(1'b1);
        check("a_drained", 64'(id_valid), 64'd0);

        // Stall decode, let fetch run until back-pressure stops it at 14 entries.
        k = 0;
        for (int c = 0; c < 40; c++) begin
            logic r, d;
            r = !ibuffer_full;
            d = outstanding() > 0;
            pc = 32'h1000 + 32'(4 * k);
            if (r) k++;
            step(r, pc, d, pc ^ 32'h5555_0000, 1'b0, 1'b0, 1'b0);
        end
        check("b_accepts", 64'(k), 64'd14);
        check("b_full", 64'(ibuffer_full), 64'd1);
        check("b_head", 64'(id_pc), 64'h1000);
        for (int j = 0; j < 14; j++) begin
            idle(1'b1);
            if (j == 0) check("b_full_drop", 64'(ibuffer_full), 64'd0);
            if (j < 13) check("b_order", 64'(id_pc), 64'(32'h1000 + 32'(4 * (j + 1))));
        end
        check("b_empty", 64'(id_valid), 64'd0);

        // Flush with two requests in flight; only the post-flush request survives.
        step(1'b1, 32'hBFC0_0100, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
        step(1'b1, 32'hBFC0_0104, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
        step(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
        step(1'b1, 32'hBFC0_0380, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
        step(1'b0, 32'h0, 1'b1, 32'hDEAD_0001, 1'b0, 1'b0, 1'b0);
        check("f_drop0", 64'(id_valid), 64'd0);
        step(1'b0, 32'h0, 1'b1, 32'hDEAD_0002, 1'b0, 1'b0, 1'b0);
        check("f_drop1", 64'(id_valid), 64'd0);
        step(1'b0, 32'h0, 1'b1, 32'h2401_0380, 1'b0, 1'b0, 1'b0);
        check("f_pc", 64'(id_pc), 64'hBFC0_0380);
        check("f_inst", 64'(id_inst), 64'h2401_0380);
        idle(1'b1);

        // Branch coinciding with a live return and a new accept.
        step(1'b1, 32'hBFC0_0200, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
        step(1'b1, 32'hBFC0_0204, 1'b1, 32'hBAD0_0001, 1'b0, 1'b0, 1'b1);
        check("br_empty", 64'(id_valid), 64'd0);
        step(1'b0, 32'h0, 1'b1, 32'hBAD0_0002, 1'b0, 1'b0, 1'b0);
        check("br_dropped", 64'(id_valid), 64'd0);
        step(1'b1, 32'hBFC0_0300, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
        step(1'b0, 32'h0, 1'b1, 32'h0000_2222, 1'b0, 1'b0, 1'b0);
        check("br_pc", 64'(id_pc), 64'hBFC0_0300);
        idle(1'b1);

        // Keep 15 entries resident while streaming through several pointer wraps.
        step(1'b1, 32'h2000, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
        for (int i = 1; i < 60; i++) begin
            pc = 32'h2000 + 32'(4 * (i - 1));
            step(1'b1, 32'h2000 + 32'(4 * i), 1'b1, pc ^ 32'hA5A5_0000, (i >= 16), 1'b0, 1'b0);
        end
        check("w_head", 64'(id_pc), 64'h20B0);
        check("w_inst", 64'(id_inst), 64'(32'h20B0 ^ 32'hA5A5_0000));
        step(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
        step(1'b0, 32'h0, 1'b1, 32'h0, 1'b0, 1'b0, 1'b0);

        // Reset arriving with five entries buffered.
        for (int i = 0; i < 5; i++) begin
            step(1'b1, 32'h3000 + 32'(4 * i), 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
            step(1'b0, 32'h0, 1'b1, 32'(i), 1'b0, 1'b0, 1'b0);
        end
        check("r_five", 64'(id_valid), 64'd1);
        @(negedge clk);
        resetn = 1'b0;
        #1;
        check("r_async", 64'(id_valid), 64'd0);
        @(posedge clk);
        #2;
        check("r_full", 64'(ibuffer_full), 64'd0);
        check("r_pc", 64'(id_pc), 64'd0);
        @(negedge clk);
        resetn = 1'b1;
        step(1'b0, 32'h0, 1'b1, 32'h0000_0077, 1'b1, 1'b0, 1'b0);
        check("r_orphan", 64'(id_valid), 64'd0);

        // Randomized traffic under the fetch-side protocol.
        repeat (3000) begin
            @(negedge clk);
            inst_req     = (outstanding() < 2) && !model_full() && ($urandom_range(0, 3) != 0);
            inst_addr_ok = ($urandom_range(0, 3) != 0);
            inst_pc      = $urandom & 32'hFFFF_FFFC;
            inst_data_ok = (outstanding() > 0) && ($urandom_range(0, 1) == 1);
            inst_rdata   = $urandom;
            id_ready     = ($urandom_range(0, 4) < 3);
            flush        = ($urandom_range(0, 39) == 0);
            branch_flag  = ($urandom_range(0, 39) == 0);
        end
        @(negedge clk);
        inst_req = 1'b0; inst_data_ok = 1'b0; flush = 1'b0; branch_flag = 1'b0;
        repeat (3) @(posedge clk);
        #3;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
